// File: rtl/bus_ram_responder.sv
// Byte-addressable RAM responder on the shared tri-state system bus.
// A request is accepted when the address hits the window; fc_bus rises after WAIT_STATES extra cycles.
//
// state | meaning
// IDLE  | no transaction; bus lines released
// WAIT  | request accepted, counting down wait states
// DONE  | access performed; fc_bus (and read data) driven until the strobe drops
module bus_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000,
    parameter int          SIZE_BYTES  = 1024,
    parameter int          WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr_bus,
    inout  wire logic [31:0] data_bus,
    input  logic             rd_bus,
    input  logic             wr_bus,
    input  logic [3:0]       data_mask_bus,
    inout  wire logic        fc_bus,
    output logic             busy
);

    localparam int OFF_W = $clog2(SIZE_BYTES);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [OFF_W:0] SIZE_W = (OFF_W + 1)'(SIZE_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t           state, state_nx;
    logic [3:0]       cnt, cnt_nx;
    logic             access;
    logic             valid, hit, req;
    logic [OFF_W-1:0] off;
    logic [31:0]      rdata;
    logic [31:0]      rd_word;
    logic [OFF_W:0]   idx [4];
    logic [3:0]       in_range;
    logic [7:0]       mem [SIZE_BYTES];

    assign valid = rd_bus ^ wr_bus;
    // BASE_ADDR is SIZE_BYTES-aligned, so an upper-bit compare is the range check.
    assign hit   = (addr_bus[31:OFF_W] == BASE_ADDR[31:OFF_W]);
    assign req   = hit & valid;
    assign off   = addr_bus[OFF_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Once accepted, only the strobe is watched; the address is not re-decoded.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        access   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_STATES > 0) begin
                        state_nx = ST_WAIT;
                        cnt_nx   = CNT_LOAD;
                    end else begin
                        access   = 1'b1;
                        state_nx = ST_DONE;
                    end
                end
            end
            ST_WAIT: begin
                if (!valid) begin
                    state_nx = ST_IDLE;
                end else if (cnt == 4'd0) begin
                    access   = 1'b1;
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_DONE: begin
                if (!valid) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_word = 32'd0;
        for (int i = 0; i < 4; i++) begin
            idx[i]      = {1'b0, off} + (OFF_W + 1)'(i);
            in_range[i] = (idx[i] < SIZE_W);
            if (in_range[i]) rd_word[8*i +: 8] = mem[idx[i][OFF_W-1:0]];
        end
    end

    // Lanes past the end of the region are dropped; there is no wrap-around.
    always_ff @(posedge clk) begin
        if (rst && access && wr_bus) begin
            for (int i = 0; i < 4; i++) begin
                if (data_mask_bus[i] && in_range[i]) mem[idx[i][OFF_W-1:0]] <= data_bus[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= 32'd0;
        end else if (access && rd_bus) begin
            rdata <= rd_word;
        end
    end

    assign busy     = (state != ST_IDLE);
    assign fc_bus   = req ? (state == ST_DONE) : 1'bz;
    assign data_bus = (req && rd_bus && state == ST_DONE) ? rdata : 32'bz;

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: transaction-level RAM model checked every cycle,
// plus directed transactions with hand-computed literal expectations.
module tb_bus_ram_responder;

    localparam logic [31:0] BASE = 32'h1000;
    localparam int          SIZE = 1024;
    localparam int          WS   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        drv_en = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic        busy;
    wire  [31:0] data_bus;
    wire         fc_bus;

    int cmp_cnt = 0;
    int err_cnt = 0;

    assign data_bus = drv_en ? wdata : 32'bz;

    bus_ram_responder #(.BASE_ADDR(BASE), .SIZE_BYTES(SIZE), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .addr_bus(addr), .data_bus(data_bus), .rd_bus(rd),
        .wr_bus(wr), .data_mask_bus(mask), .fc_bus(fc_bus), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_released(input string nm);
        cmp_cnt++;
        if (fc_bus === 1'b1) begin
            err_cnt++;
            $display("FAIL %s: fc_bus got 1 expected released at %0t", nm, $time);
        end
    endtask

    // Transaction-level model: a request held for WS+1 sampled edges completes once.
    logic [7:0]  m_mem [SIZE];
    logic [31:0] m_rdata = 32'd0;
    int          m_cnt = 0;
    bit          started = 0;

    function automatic bit m_req();
        longint a;
        a = longint'(addr);
        return (a >= longint'(BASE)) && (a < longint'(BASE) + SIZE) && (rd != wr);
    endfunction

    initial for (int i = 0; i < SIZE; i++) m_mem[i] = 8'h00;

    always @(posedge clk) begin
        int prev, off;
        started = 1;
        prev = m_cnt;
        if (!rst) begin
            m_cnt = 0;
        end else if (m_req()) begin
            if (m_cnt <= WS) m_cnt++;
            if (m_cnt == WS + 1 && prev != WS + 1) begin
                off = int'(addr - BASE);
                for (int i = 0; i < 4; i++) begin
                    if (wr) begin
                        if (mask[i] && off + i < SIZE) m_mem[off+i] = wdata[8*i +: 8];
                    end else begin
                        m_rdata[8*i +: 8] = (off + i < SIZE) ? m_mem[off+i] : 8'h00;
                    end
                end
            end
        end else begin
            m_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", {31'd0, busy}, {31'd0, m_cnt > 0});
            if (m_req()) chk("fc", {31'd0, fc_bus}, {31'd0, m_cnt == WS + 1});
            else chk_released("fc_idle");
            if (m_req() && rd && m_cnt == WS + 1) begin
                chk("rdata", data_bus, m_rdata);
            end else if (!drv_en) begin
                cmp_cnt++;
                if (data_bus !== 32'bz && data_bus !== 32'd0) begin
                    err_cnt++;
                    $display("FAIL data_release: got %h expected released at %0t", data_bus, $time);
                end
            end
        end
    end

    task automatic xact(input logic [31:0] a, input bit is_wr, input logic [31:0] wd,
                        input logic [3:0] m, input int hold, output logic [31:0] rv, output int lat);
        int n;
        @(posedge clk);
        #1;
        addr = a; mask = m; wdata = wd; drv_en = is_wr; wr = is_wr; rd = !is_wr;
        lat = 0;
        for (n = 0; n < 40; n++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (fc_bus === 1'b1) break;
        end
        if (n == 40) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL fc_timeout: got no fc_bus expected fc_bus within 40 cycles, addr %h", a);
        end
        rv = data_bus;
        repeat (hold) @(negedge clk);
        #1;
        rd = 0; wr = 0; drv_en = 0;
    endtask

    logic [31:0] rv;
    int          lat;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk_released("reset_fc");
        #1 rst = 1;

        xact(BASE + 32'h000, 1, 32'hCAFEF00D, 4'hF, 0, rv, lat);
        xact(BASE + 32'h010, 1, 32'h00000000, 4'hF, 0, rv, lat);
        xact(BASE + 32'h014, 1, 32'h00000000, 4'hF, 0, rv, lat);
        xact(BASE + 32'h020, 1, 32'h0BADF00D, 4'hF, 0, rv, lat);
        xact(BASE + 32'h3FC, 1, 32'h00000000, 4'hF, 0, rv, lat);

        xact(BASE + 32'h010, 1, 32'hDEADBEEF, 4'hF, 0, rv, lat);
        chk("write_latency", 32'(lat), 32'd3);
        xact(BASE + 32'h010, 0, 32'h0, 4'hF, 0, rv, lat);
        chk("read_latency", 32'(lat), 32'd3);
        chk("read_word", rv, 32'hDEADBEEF);

        xact(BASE + 32'h011, 1, 32'h000000AA, 4'b0001, 0, rv, lat);
        xact(BASE + 32'h010, 0, 32'h0, 4'hF, 0, rv, lat);
        chk("byte_lane", rv, 32'hDEADAAEF);
        xact(BASE + 32'h012, 0, 32'h0, 4'h0, 0, rv, lat);
        chk("unaligned", rv, 32'h0000DEAD);

        xact(BASE + SIZE - 2, 1, 32'h44332211, 4'hF, 0, rv, lat);
        xact(BASE + SIZE - 2, 0, 32'h0, 4'hF, 0, rv, lat);
        chk("region_end", rv, 32'h00002211);
        xact(BASE, 0, 32'h0, 4'hF, 0, rv, lat);
        chk("no_wrap", rv, 32'hCAFEF00D);

        @(posedge clk);
        #1;
        addr = BASE + 32'h20; wdata = 32'h12345678; mask = 4'hF; wr = 1; drv_en = 1;
        repeat (2) begin
            @(negedge clk);
            chk("abort_fc", {31'd0, fc_bus}, 32'd0);
        end
        #1 wr = 0; drv_en = 0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_busy", {31'd0, busy}, 32'd0);
            chk_released("abort_fc_rel");
        end
        xact(BASE + 32'h020, 0, 32'h0, 4'hF, 0, rv, lat);
        chk("abort_old", rv, 32'h0BADF00D);

        xact(BASE + 32'h010, 0, 32'h0, 4'hF, 10, rv, lat);
        chk("held_read", rv, 32'hDEADAAEF);
        chk("held_fc", {31'd0, fc_bus}, 32'd1);
        @(negedge clk);
        chk_released("held_drop");

        @(posedge clk);
        #1 addr = BASE - 4; rd = 1;
        repeat (4) begin
            @(negedge clk);
            chk("miss_busy", {31'd0, busy}, 32'd0);
            chk_released("miss_fc");
        end
        #1 addr = BASE + 32'h10; rd = 1; wr = 1;
        repeat (4) begin
            @(negedge clk);
            chk("both_busy", {31'd0, busy}, 32'd0);
            chk_released("both_fc");
        end
        #1 rd = 0; wr = 0;

        xact(BASE + 32'h014, 1, 32'h55667788, 4'b1010, 0, rv, lat);
        xact(BASE + 32'h014, 0, 32'h0, 4'hF, 0, rv, lat);
        chk("sparse_mask", rv, 32'h55007700);

        @(posedge clk);
        #1 addr = BASE + 32'h10; rd = 1;
        for (int n = 0; n < 40 && fc_bus !== 1'b1; n++) @(negedge clk);
        chk("rst_pre_fc", {31'd0, fc_bus}, 32'd1);
        #1 rst = 0;
        @(posedge clk);
        #1 rst = 1; rd = 0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk_released("rst_fc");
        xact(BASE + 32'h010, 0, 32'h0, 4'hF, 0, rv, lat);
        chk("rst_keep_ram", rv, 32'hDEADAAEF);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
